// File: rtl/time_keeper.sv
// time_keeper: 24-hour HH:MM:SS counter driven by a 1 Hz tick derived
// from the board clock. It has a button-driven set mode and a seconds
// clear. The hrs/min/sec outputs are binary and come straight from
// registers.
module time_keeper #(
  parameter int CLK_HZ   = 100000000,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run_en,
  input  logic       set_mode,
  input  logic       btn_hr,
  input  logic       btn_min,
  input  logic       btn_clr,
  output logic [4:0] hrs,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_tick
);

  // Guard against a zero-width counter when CLK_HZ is 1.
  localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PSC_TC = PW'(CLK_HZ - 1);
  localparam logic [4:0]    HMAX   = 5'(HOUR_MAX);
  localparam logic [5:0]    MS_MAX = 6'd59;

  logic [PW-1:0] psc, psc_nxt;
  logic [4:0]    hrs_nxt;
  logic [5:0]    min_nxt, sec_nxt;
  logic          hr_q, min_q, clr_q;
  logic          hr_rise, min_rise, clr_rise;
  logic          counting, tick;

  // Button rising edges. Hour and minute edges only count in set mode.
  // Clear counts in every mode, and it outranks a coincident tick.
  always_comb begin
    hr_rise  = btn_hr  & ~hr_q  & set_mode;
    min_rise = btn_min & ~min_q & set_mode;
    clr_rise = btn_clr & ~clr_q;
    counting = run_en & ~set_mode;
    tick     = counting & (psc == PSC_TC) & ~clr_rise;
  end

  // Next time value. The tick carry chain and the set-mode increments are
  // mutually exclusive because counting is gated off in set mode.
  always_comb begin
    psc_nxt = psc;
    sec_nxt = sec;
    min_nxt = min;
    hrs_nxt = hrs;
    if (clr_rise) begin
      psc_nxt = '0;
      sec_nxt = '0;
    end else if (counting) begin
      if (psc == PSC_TC) begin
        psc_nxt = '0;
        if (sec == MS_MAX) begin
          sec_nxt = '0;
          if (min == MS_MAX) begin
            min_nxt = '0;
            hrs_nxt = (hrs == HMAX) ? 5'd0 : hrs + 5'd1;
          end else begin
            min_nxt = min + 6'd1;
          end
        end else begin
          sec_nxt = sec + 6'd1;
        end
      end else begin
        psc_nxt = psc + 1'b1;
      end
    end
    if (hr_rise)
      hrs_nxt = (hrs == HMAX) ? 5'd0 : hrs + 5'd1;
    if (min_rise)
      min_nxt = (min == MS_MAX) ? 6'd0 : min + 6'd1;
  end

  // State registers. During reset the edge detectors load the live button
  // levels, so a button held through reset does nothing when reset drops.
  always_ff @(posedge clk) begin
    hr_q  <= btn_hr;
    min_q <= btn_min;
    clr_q <= btn_clr;
    if (reset) begin
      psc      <= '0;
      hrs      <= '0;
      min      <= '0;
      sec      <= '0;
      sec_tick <= 1'b0;
    end else begin
      psc      <= psc_nxt;
      hrs      <= hrs_nxt;
      min      <= min_nxt;
      sec      <= sec_nxt;
      sec_tick <= tick;
    end
  end

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed test of time_keeper with CLK_HZ=4, so one second
// is four clocks. Expected values are worked out by hand.
module tb_time_keeper;
  logic       clk = 1'b0;
  logic       reset = 1'b1, run_en = 1'b0, set_mode = 1'b0;
  logic       btn_hr = 1'b0, btn_min = 1'b0, btn_clr = 1'b0;
  logic [4:0] hrs;
  logic [5:0] min, sec;
  logic       sec_tick;
  int         n_tests = 0, n_fail = 0;
  int         t;

  always #5 clk = ~clk;

  time_keeper #(.CLK_HZ(4), .HOUR_MAX(23)) dut (
    .clk(clk), .reset(reset), .run_en(run_en), .set_mode(set_mode),
    .btn_hr(btn_hr), .btn_min(btn_min), .btn_clr(btn_clr),
    .hrs(hrs), .min(min), .sec(sec), .sec_tick(sec_tick)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic chk_hms(input string tag, input int h, input int m, input int s);
    chk({tag, ".hrs"}, int'(hrs), h);
    chk({tag, ".min"}, int'(min), m);
    chk({tag, ".sec"}, int'(sec), s);
  endtask

  task automatic run(input int n, output int ticks);
    ticks = 0;
    repeat (n) begin
      step();
      ticks += int'(sec_tick);
    end
  endtask

  task automatic press_hr(input int n);
    repeat (n) begin
      btn_hr = 1'b1; step();
      btn_hr = 1'b0; step();
    end
  endtask

  task automatic press_min(input int n);
    repeat (n) begin
      btn_min = 1'b1; step();
      btn_min = 1'b0; step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, then free run: a tick on every 4th edge.
    do_reset();
    chk_hms("rst", 0, 0, 0);
    chk("rst.tick", int'(sec_tick), 0);
    run_en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("free.tick", int'(sec_tick), (i % 4 == 3) ? 1 : 0);
    end
    chk_hms("free", 0, 0, 3);

    // Set-mode increments, hold, simultaneous edges, and ignored presses.
    do_reset();
    set_mode = 1'b1;
    press_min(61);
    chk_hms("setmin", 0, 1, 0);
    press_hr(25);
    chk_hms("sethr", 1, 1, 0);
    btn_hr = 1'b1;
    repeat (10) step();
    btn_hr = 1'b0; step();
    chk("hold.hrs", int'(hrs), 2);
    btn_hr = 1'b1; btn_min = 1'b1; step();
    chk_hms("both", 3, 2, 0);
    btn_hr = 1'b0; btn_min = 1'b0; step();
    set_mode = 1'b0; run_en = 1'b0;
    press_hr(2); press_min(2);
    chk_hms("noset", 3, 2, 0);

    // Minute carry from 00:00:59.
    do_reset();
    run_en = 1'b1;
    run(236, t);
    chk("c1.ticks", t, 59);
    chk_hms("c1.pre", 0, 0, 59);
    run(4, t);
    chk("c1.tick1", t, 1);
    chk_hms("c1", 0, 1, 0);

    // Hour carry from 00:59:59.
    do_reset();
    set_mode = 1'b1;
    press_min(59);
    set_mode = 1'b0;
    run(236, t);
    chk_hms("c2.pre", 0, 59, 59);
    run(4, t);
    chk_hms("c2", 1, 0, 0);

    // Day rollover from 23:59:59.
    do_reset();
    set_mode = 1'b1;
    press_hr(23); press_min(59);
    set_mode = 1'b0;
    run(236, t);
    chk_hms("roll.pre", 23, 59, 59);
    run(4, t);
    chk("roll.ticks", t, 1);
    chk_hms("roll", 0, 0, 0);

    // Clear in the terminal prescaler cycle at sec=10 discards the tick.
    do_reset();
    run(40, t);
    chk("clr.pre", int'(sec), 10);
    run(3, t);
    btn_clr = 1'b1; step();
    chk_hms("clr", 0, 0, 0);
    chk("clr.tick", int'(sec_tick), 0);
    btn_clr = 1'b0;
    run(3, t);
    chk("clr.quiet", t, 0);
    step();
    chk("clr.next", int'(sec_tick), 1);
    chk("clr.sec", int'(sec), 1);

    // Freeze with run_en=0, then resume from the held prescaler.
    run_en = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("frz.sec", int'(sec), 1);
      chk("frz.tick", int'(sec_tick), 0);
    end
    run_en = 1'b1;
    run(4, t);
    chk("res.ticks", t, 1);
    chk("res.sec", int'(sec), 2);

    // Reset at 05:07:30 with btn_min held, then release reset.
    do_reset();
    set_mode = 1'b1;
    press_hr(5); press_min(7);
    set_mode = 1'b0;
    run(120, t);
    chk_hms("mid.pre", 5, 7, 30);
    set_mode = 1'b1; btn_min = 1'b1; reset = 1'b1;
    step();
    chk_hms("mid.rst", 0, 0, 0);
    chk("mid.tick", int'(sec_tick), 0);
    reset = 1'b0;
    step(); step();
    chk("mid.held", int'(min), 0);
    btn_min = 1'b0; step();
    chk("mid.rel", int'(min), 0);
    press_min(1);
    chk("mid.press", int'(min), 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
